// File: rtl/and_tree_pipe.sv
// Pipelined reduction tree (AND/OR/XOR/NAND) over a WIDTH-bit vector, one register per tree level,
// with a per-sample valid bit, level-1 pair results aligned to the final bit, and a saturating hit counter.
module and_tree_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           mode,
    input  logic                 clr_count,
    output logic                 out_valid,
    output logic                 out,
    output logic [WIDTH/2-1:0]   pair_out,
    output logic [CNT_W-1:0]     hit_count
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int HALF   = WIDTH / 2;
    // Intermediate levels only; the last level is the out/pair_out register itself.
    localparam int INT_N  = (LEVELS > 1) ? LEVELS - 1 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Mode 11 shares the AND operator; its inversion is applied only to the final bit.
    function automatic logic op_bit(input logic a, input logic b, input logic [1:0] m);
        case (m)
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [HALF-1:0] reduce_pairs(input logic [WIDTH-1:0] v, input logic [1:0] m);
        logic [HALF-1:0] r;
        r = '0;
        for (int i = 0; i < HALF; i++) begin
            r[i] = op_bit(v[2*i+1], v[2*i], m);
        end
        return r;
    endfunction

    logic [HALF-1:0]  data_q  [INT_N];
    logic [1:0]       mode_q  [INT_N];
    logic [INT_N-1:0] valid_q;
    logic [HALF-1:0]  pair_q  [INT_N];

    // Inputs seen by each level: level 0 takes the ports, level l takes the registers of level l-1.
    logic [WIDTH-1:0] stage_in    [LEVELS];
    logic [1:0]       stage_mode  [LEVELS];
    logic [LEVELS-1:0] stage_valid;
    logic [HALF-1:0]  stage_pair  [LEVELS];
    logic             fin_bit;

    always_comb begin
        stage_in[0]    = in_data;
        stage_mode[0]  = mode;
        stage_valid[0] = in_valid;
        stage_pair[0]  = reduce_pairs(in_data, mode);
        for (int l = 1; l < LEVELS; l++) begin
            stage_in[l]    = WIDTH'(data_q[l-1]);
            stage_mode[l]  = mode_q[l-1];
            stage_valid[l] = valid_q[l-1];
            stage_pair[l]  = pair_q[l-1];
        end
        fin_bit = op_bit(stage_in[LEVELS-1][1], stage_in[LEVELS-1][0], stage_mode[LEVELS-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < INT_N; l++) begin
                data_q[l] <= '0;
                mode_q[l] <= '0;
                pair_q[l] <= '0;
            end
            valid_q   <= '0;
            out_valid <= 1'b0;
            out       <= 1'b0;
            pair_out  <= '0;
        end else begin
            for (int l = 0; l < LEVELS - 1; l++) begin
                data_q[l]  <= reduce_pairs(stage_in[l], stage_mode[l]);
                mode_q[l]  <= stage_mode[l];
                valid_q[l] <= stage_valid[l];
                pair_q[l]  <= stage_pair[l];
            end
            out_valid <= stage_valid[LEVELS-1];
            // Results hold across bubbles so the display stage keeps the last sample.
            if (stage_valid[LEVELS-1]) begin
                out      <= fin_bit ^ (stage_mode[LEVELS-1] == 2'b11);
                pair_out <= stage_pair[LEVELS-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (clr_count) begin
            hit_count <= '0;
        end else if (out_valid && out && (hit_count != CNT_MAX)) begin
            hit_count <= hit_count + 1'b1;
        end
    end

endmodule

// File: doc/and_tree_pipe.md
# and_tree_pipe

Parametrised, pipelined reduction tree over a WIDTH-bit input vector. It generalises the fixed four-input AND lab block: the pair results remain visible, the operator is selectable, every tree level is registered, and a valid bit tracks each sample. A saturating counter tallies results equal to 1. It sits between the switch/stimulus logic and the LED/display stage of the lab designs.

## Interface
- WIDTH, 8: input vector width; power of two, ≥ 2
- CNT_W, 8: hit counter width, ≥ 1
- LEVELS (localparam) = log2(WIDTH): pipeline depth
- clk  input  1  clock, rising edge
- rst  input  1  reset; one clock, reset is asynchronous and active-high
- in_valid  input  1  in_data/mode hold a sample this cycle
- in_data  input  WIDTH  operand bits
- mode  input  2  00 AND, 01 OR, 10 XOR, 11 NAND
- clr_count  input  1  synchronous clear of hit_count
- out_valid  output  1  out/pair_out hold a new result this cycle
- out  output  1  reduction result
- pair_out  output  WIDTH/2  level-1 pair results of the same sample
- hit_count  output  CNT_W  number of results with out=1, saturating

## Operation
- Level 1: pair[i] = op(in_data[2i+1], in_data[2i]), i = 0..WIDTH/2-1. Each further level applies op to adjacent pairs of the previous level. This repeats until one bit remains.
- op is AND for modes 00 and 11, OR for 01, and XOR for 10. In mode 11 only the final bit is inverted. pair_out always shows the uninverted level-1 op.
- mode is captured with the sample at level 1 and carried down the pipeline. A mode change therefore affects only later samples, and mixed-mode streams are legal.
- Each level has a valid bit. Valid shifts down one level per cycle. Level data registers may load every cycle.
- out, pair_out: load only when the last level's valid input is 1. They hold their value otherwise, including across bubbles.
- pair_out passes through LEVELS-1 delay registers so that it corresponds to the same sample as out.
- hit_count: increments by 1 on the edge after a cycle with out_valid=1 and out=1.
  - Saturates at 2^CNT_W-1.
  - clr_count=1 forces 0 and takes priority over a simultaneous increment.
- WIDTH=2: LEVELS=1, and pair_out equals out except in mode 11.
- Reset (any time, asynchronous): all valid bits, out_valid, out, pair_out and hit_count go to 0. In-flight samples are discarded; none emerges after rst falls.

## Timing
- Throughput: one sample per cycle, with no stall input. in_valid=0 inserts a bubble.
- Latency: a sample captured at edge k yields out_valid=1 for exactly one cycle after edge k+LEVELS-1.
  - WIDTH=8: the third edge after presentation, counting the capture edge as the first.
- hit_count reflects the result one edge later, at edge k+LEVELS.
- out_valid pattern equals the in_valid pattern delayed by LEVELS cycles.
- Outputs are registered; there are no combinational paths from any input to any output.
- The first rising edge after rst deasserts may capture a sample normally.

## Test plan
- Reset: assert rst mid-cycle with random inputs → out_valid, out, pair_out and hit_count are 0 immediately (asynchronous) and stay 0 until valid data flows.
- WIDTH=8, mode 00, in_data 8'hFF valid for one cycle → a single out_valid pulse 3 edges later, out=1, pair_out=4'hF; hit_count=1 one edge later.
- Mode 00, in_data 8'hF7 → out=0, pair_out=4'hD, hit_count unchanged.
- Back-to-back with mode switching: (00,8'hFF), (10,8'h01), (01,8'h00), (11,8'hFF) on consecutive cycles → four consecutive out_valid cycles.
  - out = 1,1,0,0; pair_out = F,1,0,F; hit_count ends at +2.
- Bubbles and hold: in_valid 1,0,1 with data FF, xx, 00 in mode 00 → out_valid 1,0,1; out stays 1 through the bubble, then becomes 0.
- Counter edges, CNT_W=2:
  - 5 hits → hit_count=3 (saturated).
  - clr_count together with a hit → 0.
  - Input valid, then rst before its out_valid → no out_valid after rst release, hit_count=0.
